// File: rtl/cpu_pkg.sv
// Shared constants and FSM state encoding for the boot-time program loader.
package cpu_pkg;

  localparam int IM_DEPTH_DEF = 32;
  localparam int WORD_W       = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    ZFILL = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Load-stream byte handshake plus instruction-memory write port and status.
interface program_loader_if #(
  parameter int ADDR_W = 32
);

  logic [7:0]                  byte_i;
  logic                        byte_valid_i;
  logic                        byte_ready_o;
  logic                        im_we_o;
  logic [ADDR_W-1:0]           im_addr_o;
  logic [cpu_pkg::WORD_W-1:0]  im_data_o;
  logic                        cpu_rst_o;
  logic                        done_o;
  logic                        err_o;

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, im_we_o, im_addr_o, im_data_o, cpu_rst_o, done_o, err_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, im_we_o, im_addr_o, im_data_o, cpu_rst_o, done_o, err_o
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects accepted bytes MSB-first into 32-bit words; o_last marks the 4th byte.
module word_assembler
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_last
);

  logic [WORD_W-9:0] r_shift;
  logic [1:0]        r_cnt;

  // o_word already includes the byte being accepted this cycle
  assign o_word = {r_shift, i_byte};
  assign o_last = i_accept && (r_cnt == 2'd3);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= 2'd0;
    end else if (i_accept) begin
      r_shift <= {r_shift[WORD_W-17:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program into instruction memory, zero-fills the rest,
// then releases the CPU reset.
module program_loader
  import cpu_pkg::*;
#(
  parameter int IM_DEPTH = IM_DEPTH_DEF,
  parameter int ADDR_W   = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  program_loader_if.slave bus
);

  // state | meaning
  // IDLE  | one cycle after reset release
  // LEN   | waiting for word-count byte N
  // DATA  | collecting 4 bytes of the next word
  // WRITE | single-cycle write of the assembled word
  // ZFILL | writing zeros to the remaining words
  // DONE  | load complete, CPU released
  // ERROR | N out of range, CPU held in reset

  localparam int          IDX_W   = $clog2(IM_DEPTH + 1);
  localparam logic [31:0] DEPTH_U = 32'(IM_DEPTH);

  state_t              r_state;
  logic [IDX_W-1:0]    r_word_idx;
  logic [7:0]          r_n;
  logic                r_byte_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_data;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_word_last;
  logic [WORD_W-1:0]   w_word;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [ADDR_W-1:0]   w_addr_cur;
  logic [ADDR_W-1:0]   w_addr_inc;

  assign w_accept   = bus.byte_valid_i && r_byte_ready;
  assign w_idx_inc  = r_word_idx + 1'b1;
  assign w_addr_cur = ADDR_W'({r_word_idx, 2'b00});
  assign w_addr_inc = ADDR_W'({w_idx_inc, 2'b00});

  word_assembler u_asm (
    .i_clk    (clk_i),
    .i_rst_n  (rst_i),
    .i_accept (w_accept && (r_state == DATA)),
    .i_byte   (bus.byte_i),
    .o_word   (w_word),
    .o_last   (w_word_last)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_word_idx   <= '0;
      r_n          <= 8'd0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cpu_rst    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state      <= LEN;
          r_byte_ready <= 1'b1;
        end
        LEN: begin
          if (w_accept) begin
            r_n <= bus.byte_i;
            if (32'(bus.byte_i) > DEPTH_U) begin
              r_state      <= ERROR;
              r_byte_ready <= 1'b0;
              r_err        <= 1'b1;
            end else if (bus.byte_i == 8'd0) begin
              r_state      <= ZFILL;
              r_byte_ready <= 1'b0;
              r_we         <= 1'b1;
              r_addr       <= '0;
              r_data       <= '0;
              r_word_idx   <= '0;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_word_last) begin
            r_state      <= WRITE;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b1;
            r_addr       <= w_addr_cur;
            r_data       <= w_word;
          end
        end
        WRITE: begin
          r_word_idx <= w_idx_inc;
          if (32'(w_idx_inc) < 32'(r_n)) begin
            r_state      <= DATA;
            r_byte_ready <= 1'b1;
          end else if (32'(w_idx_inc) < DEPTH_U) begin
            r_state <= ZFILL;
            r_we    <= 1'b1;
            r_addr  <= w_addr_inc;
            r_data  <= '0;
          end else begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b1;
          end
        end
        ZFILL: begin
          if (32'(w_idx_inc) < DEPTH_U) begin
            r_word_idx <= w_idx_inc;
            r_we       <= 1'b1;
            r_addr     <= w_addr_inc;
          end else begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b1;
          end
        end
        DONE, ERROR: ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready_o = r_byte_ready;
  assign bus.im_we_o      = r_we;
  assign bus.im_addr_o    = r_addr;
  assign bus.im_data_o    = r_data;
  assign bus.cpu_rst_o    = r_cpu_rst;
  assign bus.done_o       = r_done;
  assign bus.err_o        = r_err;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter IM_DEPTH, default 32, number of 32-bit instruction-memory words.
REQ-002 SHALL have parameter ADDR_W, default 32, width of the byte address driven to instruction memory.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port byte_i, input, 8, the incoming load-stream byte.
REQ-006 SHALL have port byte_valid_i, input, 1, byte_i holds a valid byte.
REQ-007 SHALL have port byte_ready_o, output, 1, the loader accepts a byte this cycle.
REQ-008 SHALL have port im_we_o, output, 1, instruction-memory write strobe.
REQ-009 SHALL have port im_addr_o, output, ADDR_W, byte address of the write (word index x 4).
REQ-010 SHALL have port im_data_o, output, 32, the write data.
REQ-011 SHALL have port cpu_rst_o, output, 1, active-low CPU reset; 0 holds the CPU in reset.
REQ-012 SHALL have port done_o, output, 1, load complete (sticky).
REQ-013 SHALL have port err_o, output, 1, malformed stream (sticky).

Function
REQ-014 SHALL use states IDLE, LEN, DATA, WRITE, ZFILL, DONE, ERROR.
REQ-015 SHALL move IDLE->LEN on the first clock after reset release.
REQ-016 SHALL accept a byte only when byte_valid_i && byte_ready_o; byte_ready_o SHALL be 1 only in LEN and DATA.
REQ-017 In LEN, SHALL take the accepted byte as word count N: N <= IM_DEPTH -> DATA (or ZFILL if N=0); N > IM_DEPTH -> ERROR.
REQ-018 In DATA, SHALL assemble 4 accepted bytes MSB-first (first byte -> bits[31:24]); after the 4th byte -> WRITE.
REQ-019 WRITE SHALL last exactly one cycle: im_we_o=1, im_data_o=assembled word, im_addr_o=word_idx*4; byte_ready_o=0.
REQ-020 After WRITE, SHALL increment word_idx; return to DATA if fewer than N words written, else ZFILL if word_idx < IM_DEPTH, else DONE.
REQ-021 ZFILL SHALL write 32'h0 to each remaining word, one per cycle, im_we_o=1, ascending addresses, then DONE.
REQ-022 DONE SHALL hold done_o=1, cpu_rst_o=1, im_we_o=0, byte_ready_o=0 until reset.
REQ-023 ERROR SHALL hold err_o=1, cpu_rst_o=0, im_we_o=0, byte_ready_o=0 until reset; no further memory writes.
REQ-024 cpu_rst_o SHALL be 0 in every state except DONE; it rises in the cycle after the final write.
REQ-025 Idle gaps (byte_valid_i=0) in LEN/DATA SHALL stall without loss of partial word.
REQ-026 Bytes presented while byte_ready_o=0 SHALL be ignored and not consumed.
REQ-027 Total writes SHALL equal IM_DEPTH exactly for any valid N; address never exceeds (IM_DEPTH-1)*4.

Reset
REQ-028 On rst_i=0 at a rising edge: state=IDLE, word_idx=0, byte count=0, byte_ready_o=0, im_we_o=0, im_addr_o=0, im_data_o=0, cpu_rst_o=0, done_o=0, err_o=0.
REQ-029 Reset mid-load (any state) SHALL abandon the partial word and restart at IDLE; no write in that cycle.

Structure
REQ-030 Shared package cpu_pkg SHALL hold IM_DEPTH default, the state encoding typedef and the 32-bit word width constant.
REQ-031 Byte-to-word assembly (shift register plus 2-bit byte counter) SHALL be the sub-module word_assembler; FSM and address counter stay in program_loader.

Verification
REQ-032 N=2, bytes 20 08 00 05 / 8C 09 00 00 -> writes 0x20080005 @0, 0x8C090000 @4, zeros @8..@124 (30 writes), then cpu_rst_o=1, done_o=1.
REQ-033 N=0 -> 32 zero writes @0..@124 in 32 consecutive cycles, then done_o=1.
REQ-034 N=33 -> err_o=1 next cycle, no im_we_o pulse ever, cpu_rst_o stays 0.
REQ-035 N=1 with byte_valid_i toggled 1-0-1-0 per cycle -> single correct word @0, no duplicated or dropped bytes.
REQ-036 rst_i=0 after 2 bytes of word 1 then full N=1 stream -> only the post-reset word written @0; pre-reset bytes absent.
REQ-037 N=32 full stream -> 32 data writes, no ZFILL cycles, last write @124, done_o=1 one cycle later.
